// File: rtl/aes_spi_link.sv
// aes_spi_link: framed SPI slave front end for the AES core, oversampled in clk.
// Build option AES_SPI_LINK_STATUS_EN prepends a status byte to every READ frame.
module aes_spi_link #(
  parameter int K           = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  output logic [K-1:0] key,
  output logic [127:0] message,
  output logic         dir,
  output logic         start,
  input  logic         core_done,
  input  logic [127:0] translated,
  output logic         busy,
  output logic         frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_KEY,
    S_MSG,
    S_RD,
    S_STAT,
    S_DONE,
    S_DRAIN
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic sclk_s, cs_s, mosi_s;
  logic rise, fall, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign cs_rise = cs_s & ~cs_prev_q;

  state_t         state_q, state_d;
  logic [8:0]     cnt_q, cnt_d;
  logic [6:0]     hdr_sh_q, hdr_sh_d;
  logic [7:0]     hdr;
  logic [K-1:0]   key_sh_q, key_sh_d;
  logic [K-1:0]   key_q, key_d;
  logic [126:0]   msg_sh_q, msg_sh_d;
  logic [127:0]   msg_q, msg_d;
  logic [127:0]   tx_q, tx_d;
  logic [127:0]   res_q, res_d;
  logic [127:0]   res_now;
  logic           rv_now;
  logic dir_pend_q, dir_pend_d;
  logic dir_q, dir_d;
  logic start_q, start_d;
  logic busy_q, busy_d;
  logic err_q, err_d;
  logic rv_q, rv_d;
  logic miso_q, miso_d;
`ifdef AES_SPI_LINK_STATUS_EN
  logic [7:0] stat_q, stat_d;
  logic       rd_ok_q, rd_ok_d;
  logic       sticky_q, sticky_d;
`endif

  assign hdr     = {hdr_sh_q, mosi_s};
  assign rv_now  = rv_q | core_done;
  assign res_now = core_done ? translated : res_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_sh_d   = hdr_sh_q;
    key_sh_d   = key_sh_q;
    msg_sh_d   = msg_sh_q;
    key_d      = key_q;
    msg_d      = msg_q;
    tx_d       = tx_q;
    res_d      = res_q;
    dir_pend_d = dir_pend_q;
    dir_d      = dir_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    rv_d       = rv_q;
    miso_d     = miso_q;
`ifdef AES_SPI_LINK_STATUS_EN
    stat_d     = stat_q;
    rd_ok_d    = rd_ok_q;
    sticky_d   = sticky_q;
`endif
    if (core_done) begin
      res_d  = translated;
      rv_d   = 1'b1;
      busy_d = 1'b0;
    end
    if (state_q != S_IDLE && cs_rise) begin
      // a frame closed before its last field bit is an abort
      state_d = S_IDLE;
      err_d   = (state_q != S_DONE) && (state_q != S_DRAIN);
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_HDR;
            cnt_d   = '0;
          end
        end
        S_HDR: begin
          if (rise) begin
            hdr_sh_d = hdr[6:0];
            cnt_d    = cnt_q + 9'd1;
            if (cnt_q == 9'd7) begin
              cnt_d = '0;
              if (hdr[6:1] != 6'd0) begin
                state_d = S_DRAIN;
                err_d   = 1'b1;
              end else if (!hdr[7]) begin
                if (busy_q) begin
                  state_d = S_DRAIN;
                  err_d   = 1'b1;
                end else begin
                  state_d    = S_KEY;
                  dir_pend_d = hdr[0];
                end
              end else begin
`ifdef AES_SPI_LINK_STATUS_EN
                stat_d  = {rv_now, busy_q & ~core_done,
                           sticky_q, 5'd0};
                rd_ok_d = rv_now;
                tx_d    = res_now;
                state_d = S_STAT;
                err_d   = ~rv_now;
`else
                if (rv_now) begin
                  tx_d    = res_now;
                  state_d = S_RD;
                end else begin
                  state_d = S_DRAIN;
                  err_d   = 1'b1;
                end
`endif
              end
            end
          end
        end
        S_KEY: begin
          if (rise) begin
            key_sh_d = {key_sh_q[K-2:0], mosi_s};
            cnt_d    = cnt_q + 9'd1;
            if (cnt_q == 9'(K - 1)) begin
              state_d = S_MSG;
              cnt_d   = '0;
            end
          end
        end
        S_MSG: begin
          if (rise) begin
            msg_sh_d = {msg_sh_q[125:0], mosi_s};
            cnt_d    = cnt_q + 9'd1;
            if (cnt_q == 9'd127) begin
              state_d = S_DONE;
              cnt_d   = '0;
              key_d   = key_sh_q;
              msg_d   = {msg_sh_q, mosi_s};
              dir_d   = dir_pend_q;
              start_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
`ifdef AES_SPI_LINK_STATUS_EN
        S_STAT: begin
          if (fall) begin
            miso_d = stat_q[7];
            stat_d = {stat_q[6:0], 1'b0};
          end
          if (rise) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd7) begin
              cnt_d    = '0;
              sticky_d = 1'b0;
              state_d  = rd_ok_q ? S_RD : S_DRAIN;
            end
          end
        end
`endif
        S_RD: begin
          if (fall) begin
            miso_d = tx_q[127];
            tx_d   = {tx_q[126:0], 1'b0};
          end
          if (rise) begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd127) begin
              state_d = S_DONE;
              cnt_d   = '0;
              rv_d    = core_done;
            end
          end
        end
        default: ;
      endcase
    end
    if (state_d != S_RD && state_d != S_STAT) miso_d = 1'b0;
`ifdef AES_SPI_LINK_STATUS_EN
    if (err_d) sticky_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hdr_sh_q   <= '0;
      key_sh_q   <= '0;
      msg_sh_q   <= '0;
      key_q      <= '0;
      msg_q      <= '0;
      tx_q       <= '0;
      res_q      <= '0;
      dir_pend_q <= 1'b0;
      dir_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rv_q       <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_sh_q   <= hdr_sh_d;
      key_sh_q   <= key_sh_d;
      msg_sh_q   <= msg_sh_d;
      key_q      <= key_d;
      msg_q      <= msg_d;
      tx_q       <= tx_d;
      res_q      <= res_d;
      dir_pend_q <= dir_pend_d;
      dir_q      <= dir_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      rv_q       <= rv_d;
      miso_q     <= miso_d;
    end
  end

`ifdef AES_SPI_LINK_STATUS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q   <= '0;
      rd_ok_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      stat_q   <= stat_d;
      rd_ok_q  <= rd_ok_d;
      sticky_q <= sticky_d;
    end
  end
`endif

  assign miso      = miso_q;
  assign miso_oe   = ~cs_s;
  assign key       = key_q;
  assign message   = msg_q;
  assign dir       = dir_q;
  assign start     = start_q;
  assign busy      = busy_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_aes_spi_link.sv
// tb_aes_spi_link: scoreboard bench for aes_spi_link, K=128 and K=256 instances.
// READ results are queued when core_done is driven and popped at frame end.
module tb_aes_spi_link;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MSG1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_SPI_LINK_STATUS_EN
  localparam int RDN = 144;
`else
  localparam int RDN = 136;
`endif

  logic clk;
  logic reset_n_a, reset_n_b;
  logic sclk, mosi, cs_a, cs_b;
  logic core_done_a, core_done_b;
  logic [127:0] translated_a, translated_b;

  logic         miso_a, miso_oe_a, dir_a, start_a, busy_a, frame_err_a;
  logic [127:0] key_a, message_a;
  logic         miso_b, miso_oe_b, dir_b, start_b, busy_b, frame_err_b;
  logic [255:0] key_b;
  logic [127:0] message_b;

  int checks = 0;
  int errors = 0;
  int start_cnt_a = 0, err_cnt_a = 0;
  int start_cnt_b = 0, err_cnt_b = 0;
  logic [127:0] sb[$];

  aes_spi_link #(.K(128), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n_a), .sclk(sclk), .cs_n(cs_a), .mosi(mosi),
    .miso(miso_a), .miso_oe(miso_oe_a), .key(key_a), .message(message_a),
    .dir(dir_a), .start(start_a), .core_done(core_done_a),
    .translated(translated_a), .busy(busy_a), .frame_err(frame_err_a)
  );

  aes_spi_link #(.K(256), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n_b), .sclk(sclk), .cs_n(cs_b), .mosi(mosi),
    .miso(miso_b), .miso_oe(miso_oe_b), .key(key_b), .message(message_b),
    .dir(dir_b), .start(start_b), .core_done(core_done_b),
    .translated(translated_b), .busy(busy_b), .frame_err(frame_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start_a) start_cnt_a++;
    if (frame_err_a) err_cnt_a++;
    if (start_b) start_cnt_b++;
    if (frame_err_b) err_cnt_b++;
  end

  task automatic cs_lo(input int sel);
    if (sel == 0) cs_a = 1'b0;
    else cs_b = 1'b0;
    #60;
  endtask

  task automatic cs_hi(input int sel);
    #40;
    if (sel == 0) cs_a = 1'b1;
    else cs_b = 1'b1;
    #100;
  endtask

  task automatic shift(input int sel, input logic [511:0] d, input int n,
                       output logic [511:0] r);
    r = '0;
    for (int i = 0; i < n; i++) begin
      mosi = d[n-1-i];
      #40;
      r = {r[510:0], (sel == 0) ? miso_a : miso_b};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic load_a(input logic [7:0] h, input logic [127:0] k,
                        input logic [127:0] m);
    logic [511:0] r;
    cs_lo(0);
    shift(0, {h, k, m}, 264, r);
    cs_hi(0);
  endtask

  task automatic read_a(output logic [511:0] r);
    logic [511:0] d;
    d = '0;
    d[RDN-1 -: 8] = 8'h80;
    cs_lo(0);
    shift(0, d, RDN, r);
    cs_hi(0);
  endtask

  task automatic pulse_core_a(input logic [127:0] v);
    @(negedge clk);
    translated_a = v;
    core_done_a  = 1'b1;
    @(negedge clk);
    core_done_a  = 1'b0;
    sb.delete();
    sb.push_back(v);
  endtask

  task automatic pulse_core_b(input logic [127:0] v);
    @(negedge clk);
    translated_b = v;
    core_done_b  = 1'b1;
    @(negedge clk);
    core_done_b  = 1'b0;
  endtask

  task automatic test_reset;
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    #100;
    checks++;
    if ({dir_a, start_a, miso_a, miso_oe_a, busy_a, frame_err_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl_in: got %b want 000000",
               {dir_a, start_a, miso_a, miso_oe_a, busy_a, frame_err_a});
    end
    @(negedge clk);
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;
    #50;
    checks++;
    if (key_a !== '0 || message_a !== '0) begin
      errors++;
      $display("FAIL reset_data: key %h msg %h want 0", key_a, message_a);
    end
    checks++;
    if ({dir_a, start_a, miso_a, miso_oe_a, busy_a, frame_err_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 000000",
               {dir_a, start_a, miso_a, miso_oe_a, busy_a, frame_err_a});
    end
    checks++;
    if (key_b !== '0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: key %h busy %b want 0", key_b, busy_b);
    end
  endtask

  task automatic test_load;
    int s0, e0;
    logic [511:0] r;
    s0 = start_cnt_a;
    e0 = err_cnt_a;
    cs_lo(0);
    checks++;
    if (miso_oe_a !== 1'b1) begin
      errors++;
      $display("FAIL load_oe: got %b want 1", miso_oe_a);
    end
    shift(0, {8'h01, KEY1, MSG1}, 264, r);
    cs_hi(0);
    checks++;
    if (key_a !== KEY1) begin
      errors++;
      $display("FAIL load_key: got %h want %h", key_a, KEY1);
    end
    checks++;
    if (message_a !== MSG1) begin
      errors++;
      $display("FAIL load_msg: got %h want %h", message_a, MSG1);
    end
    checks++;
    if (dir_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL load_dir_busy: got %b%b want 11", dir_a, busy_a);
    end
    checks++;
    if (start_cnt_a - s0 != 1 || err_cnt_a != e0) begin
      errors++;
      $display("FAIL load_pulses: start %0d err %0d want 1 0",
               start_cnt_a - s0, err_cnt_a - e0);
    end
    checks++;
    if (miso_oe_a !== 1'b0) begin
      errors++;
      $display("FAIL load_oe_off: got %b want 0", miso_oe_a);
    end
  endtask

  task automatic test_read;
    int e0;
    logic [511:0] r;
    logic [127:0] exp;
    pulse_core_a(RES1);
    #20;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL read_busy_clr: got %b want 0", busy_a);
    end
    e0 = err_cnt_a;
    read_a(r);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL read_sb: got empty queue want 1 entry");
    end else begin
      exp = sb.pop_front();
      if (r[127:0] !== exp) begin
        errors++;
        $display("FAIL read_data: got %h want %h", r[127:0], exp);
      end
    end
`ifdef AES_SPI_LINK_STATUS_EN
    checks++;
    if (r[135:128] !== 8'h80) begin
      errors++;
      $display("FAIL read_status: got %h want 80", r[135:128]);
    end
`endif
    checks++;
    if (err_cnt_a != e0) begin
      errors++;
      $display("FAIL read_err: got %0d want 0", err_cnt_a - e0);
    end
    read_a(r);
    checks++;
    if (err_cnt_a - e0 != 1) begin
      errors++;
      $display("FAIL reread_err: got %0d want 1", err_cnt_a - e0);
    end
    checks++;
    if (r[127:0] !== '0) begin
      errors++;
      $display("FAIL reread_miso: got %h want 0", r[127:0]);
    end
`ifdef AES_SPI_LINK_STATUS_EN
    checks++;
    if (r[135:128] !== 8'h00) begin
      errors++;
      $display("FAIL reread_status: got %h want 00", r[135:128]);
    end
`endif
  endtask

  task automatic test_abort;
    int s0, e0;
    logic [511:0] r;
    s0 = start_cnt_a;
    e0 = err_cnt_a;
    cs_lo(0);
    shift(0, {8'h00, {100{1'b1}}}, 108, r);
    cs_hi(0);
    checks++;
    if (err_cnt_a - e0 != 1 || start_cnt_a != s0) begin
      errors++;
      $display("FAIL abort_pulses: err %0d start %0d want 1 0",
               err_cnt_a - e0, start_cnt_a - s0);
    end
    checks++;
    if (key_a !== KEY1 || message_a !== MSG1) begin
      errors++;
      $display("FAIL abort_hold: key %h msg %h want %h %h",
               key_a, message_a, KEY1, MSG1);
    end
  endtask

`ifdef AES_SPI_LINK_STATUS_EN
  task automatic test_status;
    int e0;
    logic [511:0] r;
    e0 = err_cnt_a;
    read_a(r);
    checks++;
    if (r[135:128] !== 8'h20 || r[127:0] !== '0) begin
      errors++;
      $display("FAIL status_first: got %h/%h want 20/0", r[135:128], r[127:0]);
    end
    read_a(r);
    checks++;
    if (r[135:128] !== 8'h00) begin
      errors++;
      $display("FAIL status_repeat: got %h want 00", r[135:128]);
    end
    checks++;
    if (err_cnt_a - e0 != 2) begin
      errors++;
      $display("FAIL status_err: got %0d want 2", err_cnt_a - e0);
    end
  endtask
`endif

  task automatic test_busy;
    int s0, e0;
    logic [511:0] r;
    logic [127:0] k2, m2;
    k2 = 128'hfeedface_01234567_89abcdef_cafef00d;
    m2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    s0 = start_cnt_a;
    load_a(8'h00, k2, m2);
    checks++;
    if (key_a !== k2 || dir_a !== 1'b0 || busy_a !== 1'b1 || start_cnt_a - s0 != 1) begin
      errors++;
      $display("FAIL busy_setup: key %h dir %b busy %b start %0d want %h 0 1 1",
               key_a, dir_a, busy_a, start_cnt_a - s0, k2);
    end
    s0 = start_cnt_a;
    e0 = err_cnt_a;
    load_a(8'h01, ~k2, ~m2);
    checks++;
    if (err_cnt_a - e0 != 1 || start_cnt_a != s0) begin
      errors++;
      $display("FAIL busy_load: err %0d start %0d want 1 0",
               err_cnt_a - e0, start_cnt_a - s0);
    end
    checks++;
    if (key_a !== k2 || message_a !== m2 || dir_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_hold: key %h msg %h dir %b want %h %h 0",
               key_a, message_a, dir_a, k2, m2);
    end
    e0 = err_cnt_a;
    cs_lo(0);
    shift(0, {8'h42, 32'hdeadbeef}, 40, r);
    checks++;
    if (err_cnt_a - e0 != 1 || r[31:0] !== '0) begin
      errors++;
      $display("FAIL hdr42: err %0d miso %h want 1 0", err_cnt_a - e0, r[31:0]);
    end
    cs_hi(0);
    checks++;
    if (err_cnt_a - e0 != 1) begin
      errors++;
      $display("FAIL drain_exit: err %0d want 1", err_cnt_a - e0);
    end
    pulse_core_a(128'h5555aaaa_12345678_9abcdef0_0badcafe);
  endtask

  task automatic test_back_to_back;
    logic [511:0] r;
    logic [127:0] k, m, res, exp;
    logic d;
    int s0, e0;
    for (int i = 0; i < 3; i++) begin
      k   = {$urandom, $urandom, $urandom, $urandom};
      m   = {$urandom, $urandom, $urandom, $urandom};
      res = {$urandom, $urandom, $urandom, $urandom};
      d   = 1'($urandom_range(0, 1));
      s0  = start_cnt_a;
      e0  = err_cnt_a;
      load_a({7'd0, d}, k, m);
      checks++;
      if (key_a !== k || message_a !== m || dir_a !== d || start_cnt_a - s0 != 1) begin
        errors++;
        $display("FAIL b2b_load%0d: key %h msg %h dir %b start %0d", i,
                 key_a, message_a, dir_a, start_cnt_a - s0);
      end
      pulse_core_a(res);
      read_a(r);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_sb%0d: got empty queue want 1 entry", i);
      end else begin
        exp = sb.pop_front();
        if (r[127:0] !== exp || err_cnt_a != e0) begin
          errors++;
          $display("FAIL b2b_read%0d: got %h err %0d want %h 0", i,
                   r[127:0], err_cnt_a - e0, exp);
        end
      end
    end
  endtask

  task automatic test_k256;
    logic [511:0] r;
    logic [255:0] kb, kc;
    logic [127:0] mb, mc;
    int s0, e0;
    kb = {8{$urandom}};
    kc = {8{$urandom}};
    mb = {4{$urandom}};
    mc = {4{$urandom}};
    kb[255] = 1'b1;
    kb[0]   = 1'b1;
    s0 = start_cnt_b;
    cs_lo(1);
    shift(1, {8'h01, kb, mb}, 392, r);
    cs_hi(1);
    checks++;
    if (key_b !== kb || message_b !== mb || dir_b !== 1'b1 || start_cnt_b - s0 != 1) begin
      errors++;
      $display("FAIL k256_load: key %h msg %h dir %b start %0d",
               key_b, message_b, dir_b, start_cnt_b - s0);
    end
    pulse_core_b(128'h1);
    cs_lo(1);
    shift(1, {8'h00, kc, 50'h3ffff0000ffff}, 314, r);
    reset_n_b = 1'b0;
    #1;
    checks++;
    if (key_b !== '0 || message_b !== '0) begin
      errors++;
      $display("FAIL k256_rst_data: key %h msg %h want 0", key_b, message_b);
    end
    checks++;
    if ({dir_b, start_b, miso_b, miso_oe_b, busy_b, frame_err_b} !== 6'b0) begin
      errors++;
      $display("FAIL k256_rst_ctl: got %b want 000000",
               {dir_b, start_b, miso_b, miso_oe_b, busy_b, frame_err_b});
    end
    cs_b = 1'b1;
    #50;
    reset_n_b = 1'b1;
    #50;
    s0 = start_cnt_b;
    e0 = err_cnt_b;
    cs_lo(1);
    shift(1, {8'h00, kc, mc}, 392, r);
    cs_hi(1);
    checks++;
    if (key_b !== kc || message_b !== mc || dir_b !== 1'b0) begin
      errors++;
      $display("FAIL k256_after_rst: key %h msg %h dir %b", key_b, message_b, dir_b);
    end
    checks++;
    if (start_cnt_b - s0 != 1 || err_cnt_b != e0) begin
      errors++;
      $display("FAIL k256_pulses: start %0d err %0d want 1 0",
               start_cnt_b - s0, err_cnt_b - e0);
    end
  endtask

  initial begin
    sclk         = 1'b0;
    mosi         = 1'b0;
    cs_a         = 1'b1;
    cs_b         = 1'b1;
    core_done_a  = 1'b0;
    core_done_b  = 1'b0;
    translated_a = '0;
    translated_b = '0;
    test_reset();
    test_load();
    test_read();
    test_abort();
`ifdef AES_SPI_LINK_STATUS_EN
    test_status();
`endif
    test_busy();
    test_back_to_back();
    test_k256();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
